// File: rtl/soc_clk_gate_ctrl.sv
// Multi-channel automatic clock-gating controller: per-channel idle/wake FSM
// driving a glitch-free latch-based clock gate.
module soc_clk_gate_ctrl #(
  parameter int NUM_CH   = 4,
  parameter int IDLE_W   = 8,
  parameter int WAKE_CYC = 2
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              SE,
  input  logic [IDLE_W-1:0] cfg_idle_thresh,
  input  logic [NUM_CH-1:0] ch_req,
  input  logic [NUM_CH-1:0] ch_force_on,
  output logic [NUM_CH-1:0] ch_ack,
  output logic [NUM_CH-1:0] ch_gated,
  output logic [NUM_CH-1:0] clk_out
);

  localparam int WCNT_W = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
  localparam logic [IDLE_W-1:0] CNT_MAX   = {IDLE_W{1'b1}};
  localparam logic [WCNT_W-1:0] WAKE_LAST = WCNT_W'(WAKE_CYC - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_GATED = 2'd2,
    ST_WAKE  = 2'd3
  } state_t;

  state_t            state_r     [NUM_CH];
  state_t            state_nxt_s [NUM_CH];
  logic [IDLE_W-1:0] cnt_r       [NUM_CH];
  logic [IDLE_W-1:0] cnt_nxt_s   [NUM_CH];
  logic [WCNT_W-1:0] wcnt_r      [NUM_CH];
  logic [WCNT_W-1:0] wcnt_nxt_s  [NUM_CH];
  logic [NUM_CH-1:0] act_s;
  logic [NUM_CH-1:0] en_r;
  logic [NUM_CH-1:0] ack_r;
  logic [NUM_CH-1:0] gated_r;
  logic [NUM_CH-1:0] gate_q_r;
  logic              thresh_on_s;

  assign act_s       = ch_req | ch_force_on;
  assign thresh_on_s = (cfg_idle_thresh != {IDLE_W{1'b0}});

  // Next-state and counter update for every channel.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_nxt_s[i] = state_r[i];
      cnt_nxt_s[i]   = cnt_r[i];
      wcnt_nxt_s[i]  = wcnt_r[i];
      case (state_r[i])
        ST_RUN: begin
          if (!act_s[i]) begin
            state_nxt_s[i] = ST_IDLE;
            cnt_nxt_s[i]   = IDLE_W'(1);
          end else begin
            state_nxt_s[i] = ST_RUN;
            cnt_nxt_s[i]   = {IDLE_W{1'b0}};
          end
        end
        ST_IDLE: begin
          // Activity wins over a threshold reached on the same edge.
          if (act_s[i]) begin
            state_nxt_s[i] = ST_RUN;
            cnt_nxt_s[i]   = {IDLE_W{1'b0}};
          end else if (thresh_on_s && (cnt_r[i] >= cfg_idle_thresh)) begin
            state_nxt_s[i] = ST_GATED;
          end else if (cnt_r[i] != CNT_MAX) begin
            cnt_nxt_s[i] = cnt_r[i] + IDLE_W'(1);
          end else begin
            cnt_nxt_s[i] = CNT_MAX;
          end
        end
        ST_GATED: begin
          if (act_s[i]) begin
            state_nxt_s[i] = ST_WAKE;
            wcnt_nxt_s[i]  = {WCNT_W{1'b0}};
          end else begin
            state_nxt_s[i] = ST_GATED;
          end
        end
        ST_WAKE: begin
          if (wcnt_r[i] == WAKE_LAST) begin
            state_nxt_s[i] = ST_RUN;
            cnt_nxt_s[i]   = {IDLE_W{1'b0}};
            wcnt_nxt_s[i]  = {WCNT_W{1'b0}};
          end else begin
            wcnt_nxt_s[i] = wcnt_r[i] + WCNT_W'(1);
          end
        end
        default: begin
          state_nxt_s[i] = ST_RUN;
          cnt_nxt_s[i]   = {IDLE_W{1'b0}};
          wcnt_nxt_s[i]  = {WCNT_W{1'b0}};
        end
      endcase
    end
  end

  // State, counters, gate enable and status flags are all registered together.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_r[i] <= ST_RUN;
        cnt_r[i]   <= {IDLE_W{1'b0}};
        wcnt_r[i]  <= {WCNT_W{1'b0}};
      end
      en_r    <= {NUM_CH{1'b1}};
      ack_r   <= {NUM_CH{1'b1}};
      gated_r <= {NUM_CH{1'b0}};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_r[i] <= state_nxt_s[i];
        cnt_r[i]   <= cnt_nxt_s[i];
        wcnt_r[i]  <= wcnt_nxt_s[i];
        en_r[i]    <= (state_nxt_s[i] != ST_GATED);
        ack_r[i]   <= (state_nxt_s[i] == ST_RUN) || (state_nxt_s[i] == ST_IDLE);
        gated_r[i] <= (state_nxt_s[i] == ST_GATED);
      end
    end
  end

  // Gate latch is closed while clk_in is high so clk_out pulses are never clipped.
  always_latch begin
    if (!clk_in) begin
      gate_q_r <= en_r | {NUM_CH{SE}};
    end
  end

  assign clk_out  = {NUM_CH{clk_in}} & gate_q_r;
  assign ch_ack   = ack_r;
  assign ch_gated = gated_r;

endmodule

// File: doc/soc_clk_gate_ctrl.md
# soc_clk_gate_ctrl

Parametrised, multi-channel automatic clock-gating controller. Each channel watches an activity request and gates its clock after a programmable run of idle cycles. On renewed activity it ungates the clock and holds off a ready acknowledge for a fixed wake-up window. It sits between the SoC clock source and per-subsystem clock trees, and replaces single hand-enabled gate cells with glitch-free, latch-based gating plus a per-channel idle/wake state machine.

## Interface
Parameters:
- NUM_CH, 4: number of independent gated clock channels (≥1).
- IDLE_W, 8: width of the idle counter and of cfg_idle_thresh.
- WAKE_CYC, 2: cycles between ungating and ch_ack assertion (≥1).

Ports:
- clk_in  input  1  free-running source clock; single clock domain.
- rst  input  1  reset, synchronous, active-high.
- SE  input  1  scan enable; forces every clk_out running; does not affect FSM state.
- cfg_idle_thresh  input  IDLE_W  consecutive idle cycles before gating; 0 disables auto-gating for all channels.
- ch_req  input  NUM_CH  per-channel activity request (level).
- ch_force_on  input  NUM_CH  per-channel software override; treated as activity.
- ch_ack  output  NUM_CH  channel clock running and stable; consumer may use the clock.
- ch_gated  output  NUM_CH  channel currently gated (status).
- clk_out  output  NUM_CH  gated clocks.

## Operation
- Per-channel FSM, states RUN, IDLE, GATED, WAKE. act[i] = ch_req[i] | ch_force_on[i].
- RUN: enable=1. If !act, go to IDLE with cnt=1. Otherwise stay, cnt=0.
- IDLE: enable=1.
  - If act, go to RUN, cnt=0.
  - Else if thresh≠0 and cnt ≥ thresh, go to GATED.
  - Else cnt = cnt+1, saturating at all-ones.
- GATED: enable=0. If act, go to WAKE with wcnt=0.
- WAKE: enable=1, wcnt increments. When wcnt == WAKE_CYC-1, go to RUN. Dropping act during WAKE does not abort; the channel completes to RUN.
- Threshold is compared live. Lowering it below the current cnt gates on the next edge. Setting it to 0 holds the channel in IDLE/RUN.
- ch_ack[i] = state ∈ {RUN, IDLE}. ch_gated[i] = (state == GATED). Both are decoded from registered state, so they are glitch-free.
- Gate cell per channel: registered enable, ORed with SE, captured by a latch transparent while clk_in is low. clk_out[i] = clk_in & latch_q. No combinational path from inputs to the latch.
- Reset: every channel goes to RUN, cnt=0, wcnt=0, enable register=1. Outputs: ch_ack=all-ones, ch_gated=0, clk_out follows clk_in from the first low phase after reset. Reset mid-WAKE or mid-GATED returns the channel to RUN the same edge.
- Channels are fully independent; there is no shared arbitration.

## Timing
- Gate off: state becomes GATED at edge N. The pulse at edge N+1 is suppressed. ch_gated rises after edge N.
- Gate on: act is sampled high in GATED at edge M, so WAKE starts at M. The clk_out pulse at edge M+1 is delivered. ch_ack rises after edge M+WAKE_CYC.
- Idle-to-gated latency: with act falling before edge K, RUN→IDLE at K and GATED at edge K+thresh. With thresh=T there are T ungated idle edges after the drop: K, K+1, …, K+T-1 are IDLE/RUN→IDLE edges, and the clock is suppressed from K+T+1.
- act re-asserting on the same edge the threshold is reached wins: the channel goes to RUN, not GATED.
- clk_out high pulses are always full clk_in high phases; no runt pulses, including on SE toggles.

## Test plan
- Reset release, thresh=4, ch_req=0 → ch_ack=1111 after reset. Each channel enters GATED at the 5th edge after reset release; clk_out stops on the next edge; ch_gated=1111.
- Channel 1 gated, ch_req[1] pulsed high for 1 cycle at edge M (WAKE_CYC=2) → clk_out[1] pulses resume from M+1, ch_ack[1] rises after M+2, then channel 1 re-gates 4 idle cycles later. Other channels are unaffected.
- thresh=3, ch_req[0] deasserted for exactly 3 cycles then reasserted on the gating edge → channel 0 goes to RUN, clk_out[0] never drops a pulse, ch_gated[0] stays 0.
- thresh=0 with all requests low for 300 cycles → no channel gates. Counter saturates at 255 without wrap. Then thresh=10 is written → all channels gate on the next edge.
- SE=1 while channels 2,3 are GATED → clk_out[2], clk_out[3] toggle with full-width pulses; ch_gated stays 1 and ch_ack stays 0. SE=0 → gating resumes with no glitch.
- rst asserted mid-WAKE on channel 0 and mid-IDLE on channel 1 → after the next edge both are in RUN, ch_ack=1111, ch_gated=0000, and cnt restarts from 0.
